// File: rtl/wmr_pkg.sv
// Shared types and constants for the wmr register slave.
package wmr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/wmr_regfile.sv
// Byte-enabled register bank with a combinational read port and an
// out-of-range flag for the shared address.
module wmr_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                oor
);

  localparam int NB = DATA_W / 8;

  logic [DEPTH-1:0][DATA_W-1:0] regs_flat;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;
      logic              hit;

      assign hit = we && (addr == ADDR_W'(gi));

      always_comb begin
        reg_d = reg_q;
        for (int b = 0; b < NB; b++) begin
          if (hit && be[b]) begin
            reg_d[b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs_flat[gi] = reg_q;
    end
  endgenerate

  // Out-of-range addresses read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        rdata = regs_flat[i];
      end
    end
  end

  assign oor = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH));

endmodule

// File: rtl/wmr_reg_slave.sv
// Four-phase start/finish register slave: latches a request, waits WAIT_CYC
// cycles, executes for one cycle against the register bank, then holds finish.
module wmr_reg_slave
  import wmr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                wren,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byteenable,
  output logic                finish,
  output logic [DATA_W-1:0]   read_data,
  output logic                err,
  output logic                busy
);

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    wren_q, wren_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W/8-1:0]     be_q, be_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    finish_q, finish_d;

  logic                    rf_we;
  logic [DATA_W-1:0]       rf_rdata;
  logic                    rf_oor;

  wmr_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (rf_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (rf_rdata),
    .oor   (rf_oor)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wren_d   = wren_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rf_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wren_d  = wren;
          addr_d  = address;
          wdata_d = write_data;
          be_d    = byteenable;
          cnt_d   = WAIT_CNT_W'(WAIT_CYC);
          state_d = (WAIT_CYC == 0) ? S_EXEC : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Out-of-range writes are dropped; reads of them return zero.
        rf_we = wren_q && !rf_oor;
        if (!wren_q) begin
          rdata_d = rf_oor ? '0 : rf_rdata;
        end
        err_d   = rf_oor;
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    finish_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      finish_q <= finish_d;
    end
  end

  assign finish    = finish_q;
  assign read_data = rdata_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_wmr_reg_slave.sv
// Self-checking bench for wmr_reg_slave: directed table, random requests
// against a register-array model, and handshake/reset corner sequences.
module tb_wmr_reg_slave;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 6;
  localparam int WAIT_CYC = 2;
  localparam int NREG     = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [3:0]        byteenable;
  logic              finish;
  logic [DATA_W-1:0] read_data;
  logic              err;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model [NREG];
  logic [DATA_W-1:0] last_rd;

  wmr_reg_slave #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .wren       (wren),
    .address    (address),
    .write_data (write_data),
    .byteenable (byteenable),
    .finish     (finish),
    .read_data  (read_data),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    last_rd = '0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    if (int'(a) < DEPTH) begin
      for (int k = 0; k < 4; k++) begin
        if (b[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
      end
    end
  endtask

  // One full handshake. Inputs are driven on the falling edge; the first
  // rising edge after that is the sampling edge (edge 1), so finish must be
  // seen after edge WAIT_CYC+2. hold = extra cycles start stays high.
  task automatic do_req(input logic wr, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int hold, input string tag,
                        output logic [31:0] rd_out, output logic err_out);
    int n;
    logic [31:0] exp_rd;
    logic        exp_err;
    exp_err = (int'(a) >= DEPTH);
    exp_rd  = wr ? last_rd : (exp_err ? 32'h0 : model[a]);
    start = 1'b1; wren = wr; address = a; write_data = d; byteenable = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, " busy"}, {31'b0, busy}, 32'd1);
        wren = $urandom; address = $urandom; write_data = $urandom; byteenable = $urandom;
      end
    end while (!finish && n < 40);
    check({tag, " latency"}, n, WAIT_CYC + 2);
    check({tag, " read_data"}, read_data, exp_rd);
    check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
    rd_out  = read_data;
    err_out = err;
    if (wr) model_write(a, d, b);
    else    last_rd = exp_rd;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " finish held"}, {31'b0, finish}, 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, " finish drop"}, {31'b0, finish}, 32'd0);
    check({tag, " busy drop"}, {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    logic        e;
    int          pulses;

    vecs[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 3'd3, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 3'd5, 32'hAABBCCDD, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 3'd5, 32'h11223344, 4'h5, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b0, 3'd5, 32'h0,        4'h0, 32'hAA22CC44, 1'b0};
    vecs[5] = '{1'b1, 3'd7, 32'hCAFEF00D, 4'hF, 32'hAA22CC44, 1'b1};
    vecs[6] = '{1'b0, 3'd7, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 3'd3, 32'h12345678, 4'h0, 32'h0,        1'b0};
    vecs[8] = '{1'b0, 3'd3, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[9] = '{1'b0, 3'd6, 32'h0,        4'h0, 32'h0,        1'b1};

    start = 1'b0; wren = 1'b0; address = '0; write_data = '0; byteenable = '0;
    reset_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset finish", {31'b0, finish}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset err", {31'b0, err}, 32'd0);
    check("reset read_data", read_data, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].b, 0, $sformatf("vec%0d", i), rd, e);
      check($sformatf("vec%0d table rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d table err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
    end

    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom), 3'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 2)),
             $sformatf("rnd%0d", i), rd, e);
    end

    // Finish stays asserted while start is held.
    do_req(1'b0, 3'd1, 32'h0, 4'h0, 10, "hold", rd, e);

    // Start dropped during WAIT: request completes, finish pulses once.
    start = 1'b1; wren = 1'b1; address = 3'd4; write_data = 32'h5A5A_0F0F; byteenable = 4'hF;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (finish) pulses++;
    end
    check("early finish pulses", pulses, 1);
    check("early busy", {31'b0, busy}, 32'd0);
    model_write(3'd4, 32'h5A5A_0F0F, 4'hF);
    do_req(1'b0, 3'd4, 32'h0, 4'h0, 0, "early readback", rd, e);
    check("early readback value", rd, 32'h5A5A_0F0F);

    // Reset during WAIT of a write to address 2.
    do_req(1'b1, 3'd2, 32'h0BADF00D, 4'hF, 0, "pre-rst wr", rd, e);
    do_req(1'b0, 3'd7, 32'h0, 4'h0, 0, "pre-rst err", rd, e);
    start = 1'b1; wren = 1'b1; address = 3'd2; write_data = 32'h7777_7777; byteenable = 4'hF;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst finish", {31'b0, finish}, 32'd0);
    check("midrst err", {31'b0, err}, 32'd0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst read_data", read_data, 32'h0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(negedge clk);
    do_req(1'b0, 3'd2, 32'h0, 4'h0, 0, "post-rst rd2", rd, e);
    check("post-rst addr2 value", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
